// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
//   Bundles the CPU request/response handshake and the data_memory port of
//   the load/store unit into a single interface.
//
//   Request  : req_valid, req_ready, req_op, req_addr, req_wdata
//   Response : rsp_valid, rsp_ready, rsp_rdata, rsp_fault
//   Memory   : mem_addr, mem_wdata, mem_we (to data_memory), mem_rdata (from it)
//
//   slave  : the load/store unit's view (takes requests, drives memory)
//   master : the CPU datapath / memory side view
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_fault;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
//   Request/response front-end for data_memory (sync write, 1-cycle
//   registered read). Accepts one LOAD / STORE / INC request at a time,
//   range-checks the address, sequences the memory accesses around the read
//   latency and returns a held response with read data or a fault flag.
//
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous reset, active-low
//     bus    : load_store_unit_if.slave (request, response and memory port)
//
//   Sequencing (edges counted from the acceptance edge):
//     fault -> RESP                           (1)
//     STORE -> ISSUE(write) -> RESP           (2)
//     LOAD  -> ISSUE -> CAP -> RESP           (3)
//     INC   -> ISSUE -> CAP -> WB(write) -> RESP (4)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int ADDR_LO = 64,
    parameter int ADDR_HI = 127
) (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LP_ADDR_LO = ADDR_W'(ADDR_LO);
    localparam logic [ADDR_W-1:0] LP_ADDR_HI = ADDR_W'(ADDR_HI);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_CAP   = 3'd2,
        S_WB    = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Increment with natural wrap at 2^DATA_W.
    function automatic logic [DATA_W-1:0] f_inc(input logic [DATA_W-1:0] v);
        return v + {{(DATA_W-1){1'b0}}, 1'b1};
    endfunction

    state_t            r_state;
    logic [1:0]        r_op;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_fault;

    state_t            w_state_nxt;
    logic [1:0]        w_op_nxt;
    logic [DATA_W-1:0] w_data_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic              w_mem_we_nxt;
    logic [DATA_W-1:0] w_rsp_rdata_nxt;
    logic              w_rsp_fault_nxt;
    logic              w_accept;
    logic              w_req_ok;

    assign w_accept = bus.req_valid && (r_state == S_IDLE);
    assign w_req_ok = (bus.req_addr >= LP_ADDR_LO) && (bus.req_addr <= LP_ADDR_HI)
                      && (bus.req_op != OP_RSVD);

    // State register plus all registered outputs and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 2'b00;
            r_data      <= {DATA_W{1'b0}};
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_we    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= {DATA_W{1'b0}};
            r_rsp_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_data      <= w_data_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_rsp_valid <= (w_state_nxt == S_RESP);
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_fault <= w_rsp_fault_nxt;
        end
    end

    // Next-state and next-output decode; outputs are computed one cycle
    // ahead so that every interface output comes straight from a flop.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_data_nxt      = r_data;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_mem_we_nxt    = 1'b0;
        w_rsp_rdata_nxt = r_rsp_rdata;
        w_rsp_fault_nxt = r_rsp_fault;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt = bus.req_op;
                    if (w_req_ok) begin
                        w_state_nxt     = S_ISSUE;
                        w_mem_addr_nxt  = bus.req_addr;
                        w_mem_wdata_nxt = bus.req_wdata;
                        w_mem_we_nxt    = (bus.req_op == OP_STORE);
                    end else begin
                        // Fault: respond immediately, memory untouched.
                        w_state_nxt     = S_RESP;
                        w_rsp_rdata_nxt = {DATA_W{1'b0}};
                        w_rsp_fault_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (r_op == OP_STORE) begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = {DATA_W{1'b0}};
                    w_rsp_fault_nxt = 1'b0;
                end else begin
                    // Read address is on the bus this cycle; data arrives in CAP.
                    w_state_nxt = S_CAP;
                end
            end
            S_CAP: begin
                w_data_nxt = bus.mem_rdata;
                if (r_op == OP_INC) begin
                    w_state_nxt     = S_WB;
                    w_mem_we_nxt    = 1'b1;
                    w_mem_wdata_nxt = f_inc(bus.mem_rdata);
                end else begin
                    w_state_nxt     = S_RESP;
                    w_rsp_rdata_nxt = bus.mem_rdata;
                    w_rsp_fault_nxt = 1'b0;
                end
            end
            S_WB: begin
                // INC returns the value seen before the increment.
                w_state_nxt     = S_RESP;
                w_rsp_rdata_nxt = r_data;
                w_rsp_fault_nxt = 1'b0;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_state_nxt     = S_IDLE;
                    w_rsp_rdata_nxt = {DATA_W{1'b0}};
                    w_rsp_fault_nxt = 1'b0;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_fault = r_rsp_fault;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
//   Directed, table-driven bench for load_store_unit with a behavioural
//   data_memory (sync write, registered read) attached to the memory port.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    load_store_unit #(.ADDR_W(8), .DATA_W(8), .ADDR_LO(64), .ADDR_HI(127)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // data_memory model: synchronous write, one-cycle registered read
    logic [7:0] mem [256];
    logic [7:0] mem_rd;
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        mem_rd <= mem[bus.mem_addr];
    end
    assign bus.mem_rdata = mem_rd;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0] op;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
        logic       exp_fault;
        int         exp_lat;
        int         exp_we;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present one request, wait for the response (bounded), report latency
    // in edges from acceptance and the number of cycles mem_we was high.
    task automatic issue(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                         output int lat, output int we_cnt);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        chk("req_ready_before_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 8'h00;
        lat    = 1;
        we_cnt = int'(bus.mem_we);
        while (!bus.rsp_valid && lat < 16) begin
            @(posedge clk);
            #1;
            lat++;
            we_cnt += int'(bus.mem_we);
        end
    endtask

    // Take the held response and check the unit returns to idle.
    task automatic release_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("rsp_valid_after_take", 32'(bus.rsp_valid), 32'd0);
        chk("req_ready_after_take", 32'(bus.req_ready), 32'd1);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        int lat, we_cnt;
        logic [8:0] rsp_q [$];
        int acc_cyc [3];
        int mon_we;
        logic [1:0] b_op   [3];
        logic [7:0] b_wd   [3];
        logic [8:0] b_exp  [3];

        //            op     addr    wdata  rdata  flt  lat we
        vecs[0]  = '{2'b01, 8'd64,  8'hA5, 8'h00, 1'b0, 2, 1};
        vecs[1]  = '{2'b00, 8'd64,  8'h00, 8'hA5, 1'b0, 3, 0};
        vecs[2]  = '{2'b00, 8'd63,  8'h00, 8'h00, 1'b1, 1, 0};
        vecs[3]  = '{2'b01, 8'd128, 8'h33, 8'h00, 1'b1, 1, 0};
        vecs[4]  = '{2'b11, 8'd100, 8'h44, 8'h00, 1'b1, 1, 0};
        vecs[5]  = '{2'b01, 8'd127, 8'hFF, 8'h00, 1'b0, 2, 1};
        vecs[6]  = '{2'b10, 8'd127, 8'h99, 8'hFF, 1'b0, 4, 1};
        vecs[7]  = '{2'b00, 8'd127, 8'h00, 8'h00, 1'b0, 3, 0};
        vecs[8]  = '{2'b01, 8'd100, 8'h7F, 8'h00, 1'b0, 2, 1};
        vecs[9]  = '{2'b10, 8'd100, 8'h12, 8'h7F, 1'b0, 4, 1};
        vecs[10] = '{2'b00, 8'd100, 8'h00, 8'h80, 1'b0, 3, 0};
        vecs[11] = '{2'b10, 8'd200, 8'h00, 8'h00, 1'b1, 1, 0};
        vecs[12] = '{2'b00, 8'd64,  8'h00, 8'hA5, 1'b0, 3, 0};
        vecs[13] = '{2'b01, 8'd80,  8'h3C, 8'h00, 1'b0, 2, 1};

        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 8'h00;
        bus.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_fault", 32'(bus.rsp_fault), 32'd0);
        chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single transactions
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, we_cnt);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), 32'(bus.rsp_rdata), 32'(vecs[i].exp_rdata));
            chk($sformatf("v%0d_fault", i), 32'(bus.rsp_fault), 32'(vecs[i].exp_fault));
            chk($sformatf("v%0d_we_cycles", i), 32'(we_cnt), 32'(vecs[i].exp_we));
            release_rsp();
        end

        // Backpressure: response held 10 cycles, stray request ignored
        issue(2'b00, 8'd64, 8'h00, lat, we_cnt);
        chk("bp_latency", 32'(lat), 32'd3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 4) begin
                bus.req_valid = 1'b1;
                bus.req_op    = 2'b01;
                bus.req_addr  = 8'd64;
                bus.req_wdata = 8'h11;
            end else begin
                bus.req_valid = 1'b0;
            end
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_rsp_rdata", 32'(bus.rsp_rdata), 32'hA5);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_mem_we",    32'(bus.mem_we),    32'd0);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        release_rsp();
        issue(2'b00, 8'd64, 8'h00, lat, we_cnt);
        chk("bp_after_rdata", 32'(bus.rsp_rdata), 32'hA5);
        release_rsp();

        // Reset during the CAP cycle of an INC to 80 (holds 8'h3C)
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b10;
        bus.req_addr  = 8'd80;
        @(posedge clk);          // accept -> ISSUE
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);          // -> CAP
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstcap_mem_we",    32'(bus.mem_we),    32'd0);
        chk("rstcap_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstcap_req_ready", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mon_we = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            mon_we += int'(bus.mem_we);
            chk("rstcap_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        chk("rstcap_no_write", 32'(mon_we), 32'd0);
        issue(2'b00, 8'd80, 8'h00, lat, we_cnt);
        chk("rstcap_load_rdata", 32'(bus.rsp_rdata), 32'h3C);
        chk("rstcap_load_fault", 32'(bus.rsp_fault), 32'd0);
        release_rsp();

        // Back-to-back: req_valid held high, rsp_ready held high
        b_op[0] = 2'b01; b_wd[0] = 8'h5A; b_exp[0] = {1'b0, 8'h00};
        b_op[1] = 2'b00; b_wd[1] = 8'h00; b_exp[1] = {1'b0, 8'h5A};
        b_op[2] = 2'b10; b_wd[2] = 8'hEE; b_exp[2] = {1'b0, 8'h5A};
        mon_we = 0;
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int g;
                    if (i > 0) @(negedge clk);
                    bus.req_valid = 1'b1;
                    bus.req_op    = b_op[i];
                    bus.req_addr  = 8'd90;
                    bus.req_wdata = b_wd[i];
                    g = 0;
                    while (!bus.req_ready && g < 20) begin
                        @(negedge clk);
                        g++;
                    end
                    if (g >= 20) chk("b2b_accept_timeout", 32'(g), 32'd0);
                    @(posedge clk);
                    #1;
                    acc_cyc[i] = cyc;
                end
                bus.req_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    @(negedge clk);
                    mon_we += int'(bus.mem_we);
                    if (bus.rsp_valid) rsp_q.push_back({bus.rsp_fault, bus.rsp_rdata});
                end
            end
        join
        bus.rsp_ready = 1'b0;
        chk("b2b_rsp_count", 32'(rsp_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rsp_q.size()) chk($sformatf("b2b_rsp%0d", i), 32'(rsp_q[i]), 32'(b_exp[i]));
        end
        // STORE occupies 2 edges + RESP cycle; LOAD 3 edges + RESP cycle
        chk("b2b_gap_store_load", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
        chk("b2b_gap_load_inc",   32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        chk("b2b_we_cycles", 32'(mon_we), 32'd2);
        issue(2'b00, 8'd90, 8'h00, lat, we_cnt);
        chk("b2b_final_rdata", 32'(bus.rsp_rdata), 32'h5B);
        release_rsp();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
